// File: rtl/wallace_mult_pkg.sv
// Elaboration-time helpers for sizing the Wallace tree and placing its register cuts.
package wallace_mult_pkg;

    // Rows left after one 3:2 level: each full triple becomes two rows, leftovers pass through.
    function automatic int rows_next(input int rows);
        return 2 * (rows / 3) + (rows % 3);
    endfunction

    function automatic int csa_levels(input int rows);
        int r;
        int n;
        r = rows;
        n = 0;
        while (r > 2) begin
            r = rows_next(r);
            n++;
        end
        return n;
    endfunction

    function automatic int rows_after(input int rows, input int levels);
        int r;
        r = rows;
        for (int i = 0; i < levels; i++) begin
            r = rows_next(r);
        end
        return r;
    endfunction

    // ceil(k*L/(P+1)): cuts are spread as evenly as the level count allows.
    function automatic int cut_level(input int k, input int l, input int p);
        return (k * l + p) / (p + 1);
    endfunction

    // How many cuts land directly after level 'lvl' (several may stack when L is small).
    function automatic int cuts_after(input int lvl, input int l, input int p);
        int n;
        n = 0;
        for (int k = 1; k <= p; k++) begin
            if (cut_level(k, l, p) == lvl) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/wallace_mult_pipe_if.sv
// Operand/result handshake bundle of the pipelined multiplier.
interface wallace_mult_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_product, out_tag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_product, out_tag, busy
    );
endinterface

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor over W-bit rows; the carry row comes out already weighted by 2.
module csa_3to2 #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);
    assign s = x ^ y ^ z;
    // The top majority bit would shift out of the row, so it is never formed.
    assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined signed/unsigned Wallace-tree multiplier: operand register, CSA tree with
// configurable cuts, final carry-propagate adder into the output register.
module wallace_mult_pipe
    import wallace_mult_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    wallace_mult_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int NR = PW;
    localparam int NL = csa_levels(NR);
    localparam int NS = PIPE_STAGES + 2;

    logic               en;
    logic [NS-1:0]      stage_valid;
    logic [TAG_W-1:0]   stage_tag [NS-1];
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               signed_q;
    logic [PW-1:0]      ext_a;
    logic [PW-1:0]      ext_b;
    logic [PW-1:0]      out_product_q;
    logic [TAG_W-1:0]   out_tag_q;

    // Row arrays: tree_in[l] feeds level l+1 (after any cuts), tree_out[l] is level l's raw result.
    logic [PW-1:0]      tree_in  [NL+1][NR];
    logic [PW-1:0]      tree_out [1:NL][NR];

    // Global stall: the whole pipe moves only when the output slot is free or being drained.
    assign en = !stage_valid[NS-1] || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else if (en) begin
            stage_valid <= {stage_valid[NS-2:0], bus.in_valid};
        end
    end

    // NOTE: operand, tag and tree registers carry no reset; stage_valid alone decides what is live.
    always_ff @(posedge clk) begin
        if (en) begin
            a_q          <= bus.in_a;
            b_q          <= bus.in_b;
            signed_q     <= bus.in_signed;
            stage_tag[0] <= bus.in_tag;
            for (int k = 1; k < NS - 1; k++) begin
                stage_tag[k] <= stage_tag[k-1];
            end
        end
    end

    assign ext_a = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};

    for (genvar i = 0; i < NR; i++) begin : g_pp
        assign tree_in[0][i] = ext_b[i] ? (ext_a << i) : '0;
    end

    for (genvar l = 1; l <= NL; l++) begin : g_lvl
        localparam int RI = rows_after(NR, l - 1);
        localparam int RO = rows_after(NR, l);
        localparam int NG = RI / 3;
        localparam int NC = cuts_after(l, NL, PIPE_STAGES);

        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_3to2 #(.W(PW)) u_csa (
                .x (tree_in[l-1][3*g]),
                .y (tree_in[l-1][3*g+1]),
                .z (tree_in[l-1][3*g+2]),
                .s (tree_out[l][2*g]),
                .c (tree_out[l][2*g+1])
            );
        end

        for (genvar j = 0; j < RI - 3 * NG; j++) begin : g_pass
            assign tree_out[l][2*NG+j] = tree_in[l-1][3*NG+j];
        end

        if (NC == 0) begin : g_wire
            for (genvar r = 0; r < RO; r++) begin : g_row
                assign tree_in[l][r] = tree_out[l][r];
            end
        end else begin : g_cut
            // Stacked cuts after one level form a short shift chain of live rows.
            logic [PW-1:0] cut_q [NC][RO];

            always_ff @(posedge clk) begin
                if (en) begin
                    for (int r = 0; r < RO; r++) begin
                        cut_q[0][r] <= tree_out[l][r];
                    end
                    for (int d = 1; d < NC; d++) begin
                        for (int r = 0; r < RO; r++) begin
                            cut_q[d][r] <= cut_q[d-1][r];
                        end
                    end
                end
            end

            for (genvar r = 0; r < RO; r++) begin : g_row
                assign tree_in[l][r] = cut_q[NC-1][r];
            end
        end

        for (genvar r = RO; r < NR; r++) begin : g_dead
            assign tree_in[l][r]  = '0;
            assign tree_out[l][r] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_product_q <= '0;
            out_tag_q     <= '0;
        end else if (en) begin
            out_product_q <= tree_in[NL][0] + tree_in[NL][1];
            out_tag_q     <= stage_tag[NS-2];
        end
    end

    assign bus.in_ready    = en && !rst;
    assign bus.out_valid   = stage_valid[NS-1];
    assign bus.out_product = out_product_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.busy        = |stage_valid;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed-vector and scoreboard bench for wallace_mult_pipe (WIDTH=32, PIPE_STAGES=2).
module tb_wallace_mult_pipe;
    localparam int WIDTH       = 32;
    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 4;
    localparam int PW          = 2 * WIDTH;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [PW-1:0]    p;
    } vec_t;

    typedef struct packed {
        logic [PW-1:0]    p;
        logic [TAG_W-1:0] t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   out_count = 0;
    int   acc_count = 0;
    exp_t sb[$];

    wallace_mult_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    wallace_mult_pipe #(
        .WIDTH       (WIDTH),
        .PIPE_STAGES (PIPE_STAGES),
        .TAG_W       (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic [TAG_W-1:0] t);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_signed = s;
        bus.in_tag    = t;
    endtask

    // Scoreboard: transfers are judged at the negedge preceding the edge that completes them.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got tag %h with no outstanding beat", bus.out_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_product", 64'(bus.out_product), 64'(e.p));
                    check("sb_tag", 64'(bus.out_tag), 64'(e.t));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_count++;
                sb.push_back('{p: model(bus.in_a, bus.in_b, bus.in_signed), t: bus.in_tag});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   first_cyc;
        int   got;
        int   idx;
        int   base;
        int   acc_base;
        int   seen;
        bit   acc;
        bit   stall_seen;
        logic [PW-1:0]    snap_p;
        logic [TAG_W-1:0] snap_t;

        vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 64'h0000_0000_8000_0000};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
        vecs[6]  = '{32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000};
        vecs[7]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
        vecs[8]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
        vecs[9]  = '{32'h0000_0003, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[10] = '{32'h0000_0003, 32'hFFFF_FFFB, 1'b0, 64'h0000_0002_FFFF_FFF1};
        vecs[11] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};

        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_product", 64'(bus.out_product), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors, one at a time, with exact latency checks.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].s, TAG_W'(i));
            @(negedge clk);
            check("tbl_in_ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            repeat (PIPE_STAGES) @(posedge clk);
            @(negedge clk);
            check("tbl_not_early", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("tbl_out_valid", 64'(bus.out_valid), 64'd1);
            check("tbl_product", 64'(bus.out_product), 64'(vecs[i].p));
            check("tbl_tag", 64'(bus.out_tag), 64'(i));
        end

        // 8 back-to-back beats, tags 0..7.
        @(posedge clk);
        #1 drive(1'b1, 32'd100, 32'd7, 1'b0, 4'd0);
        first_cyc = -1;
        got = 0;
        for (int c = 0; c < 8 + PIPE_STAGES + 6; c++) begin
            @(posedge clk);
            #1;
            if (c < 7) drive(1'b1, WIDTH'(100 + c + 1), WIDTH'(-(c + 2)), c[0], TAG_W'(c + 1));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid) begin
                if (first_cyc < 0) first_cyc = c;
                check("b2b_gapless", 64'(c), 64'(first_cyc + got));
                check("b2b_tag", 64'(bus.out_tag), 64'(got));
                got++;
            end
        end
        check("b2b_first_latency", 64'(first_cyc), 64'(PIPE_STAGES + 1));
        check("b2b_count", 64'(got), 64'd8);

        // Five-cycle output stall mid-stream.
        base = out_count;
        idx = 0;
        stall_seen = 1'b0;
        snap_p = '0;
        snap_t = '0;
        @(posedge clk);
        #1 drive(1'b1, 32'h0000_1000, 32'hFFFF_FFFE, 1'b1, 4'd8);
        for (int c = 0; c < 80 && (out_count - base) < 8; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (!bus.out_ready) begin
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                if (stall_seen) begin
                    check("stall_product_hold", 64'(bus.out_product), 64'(snap_p));
                    check("stall_tag_hold", 64'(bus.out_tag), 64'(snap_t));
                end else begin
                    snap_p = bus.out_product;
                    snap_t = bus.out_tag;
                    stall_seen = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (idx < 8) drive(1'b1, WIDTH'(32'h0000_1000 + idx), WIDTH'(32'hFFFF_FFFE - idx),
                               idx[0] ^ 1'b1, TAG_W'(8 + idx));
            else bus.in_valid = 1'b0;
            bus.out_ready = !(c >= PIPE_STAGES + 1 && c < PIPE_STAGES + 6);
        end
        bus.out_ready = 1'b1;
        check("stall_seen", 64'(stall_seen), 64'd1);
        check("stall_result_count", 64'(out_count - base), 64'd8);
        check("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with three beats in flight.
        @(posedge clk);
        #1 drive(1'b1, 32'd11, 32'd13, 1'b0, 4'd1);
        @(posedge clk);
        #1 drive(1'b1, 32'd17, 32'd19, 1'b1, 4'd2);
        @(posedge clk);
        #1 drive(1'b1, 32'd23, 32'd29, 1'b0, 4'd3);
        @(posedge clk);
        #1 begin
            bus.in_valid = 1'b0;
            rst = 1'b1;
        end
        @(negedge clk);
        check("midrst_busy_before", 64'(bus.busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_ghosts", 64'(seen), 64'd0);

        // Random traffic with random valid/ready against the scoreboard.
        base = out_count;
        acc_base = acc_count;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 1)), TAG_W'($urandom));
            bus.out_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk);
        #1 begin
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        for (int c = 0; c < 50 && bus.busy; c++) @(negedge clk);
        @(negedge clk);
        check("rand_drained", 64'(bus.busy), 64'd0);
        check("rand_sb_empty", 64'(sb.size()), 64'd0);
        check("rand_in_out_balance", 64'(out_count - base), 64'(acc_count - acc_base));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
